// File: rtl/shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encodings
// and the default operand width.
package shift_add_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        LOAD  = 3'b001,
        CHECK = 3'b010,
        ADD   = 3'b011,
        SHIFT = 3'b100,
        DONE  = 3'b101
    } state_t;

endpackage

// File: rtl/shift_add_seq_ctrl_counter.sv
// Loadable down-counter tracking the remaining multiplier bits; is_one lets
// the sequencer spot the final iteration without a zero-detect downstream.
module bit_down_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          is_one
);

    // clr outranks load so a cancel issued during LOAD still leaves zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    assign is_one = (count == CW'(1));

endmodule

// File: rtl/shift_add_seq_ctrl.sv
// Sequencer for the shift-and-add multiplier: load, then per bit an optional
// add followed by a shift, then a one-cycle done pulse. Outputs are Moore.
module shift_add_seq_ctrl
    import shift_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          lsb,
    output logic          ld,
    output logic          add,
    output logic          sh,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] bits_left,
    output logic [2:0]    state
);

    state_t state_q;
    state_t state_d;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_is_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld       = 1'b0;
        add      = 1'b0;
        sh       = 1'b0;
        done     = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                ld       = 1'b1;
                cnt_load = 1'b1;
                state_d  = CHECK;
            end
            CHECK: begin
                state_d = lsb ? ADD : SHIFT;
            end
            ADD: begin
                add     = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                sh      = 1'b1;
                cnt_dec = 1'b1;
                state_d = cnt_is_one ? DONE : CHECK;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Cancel wins over every other transition, including a start in IDLE.
        if (abort) state_d = IDLE;
    end

    bit_down_counter #(
        .CW(CW)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CW'(WIDTH)),
        .dec      (cnt_dec),
        .clr      (abort),
        .count    (bits_left),
        .is_one   (cnt_is_one)
    );

    assign busy  = (state_q != IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_shift_add_seq_ctrl.sv
// Bench for shift_add_seq_ctrl: emulates the multiplier datapath around the
// sequencer and checks timing, strobe counts and the resulting product.
module tb_shift_add_seq_ctrl;
    import shift_add_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          lsb;
    logic          ld;
    logic          add;
    logic          sh;
    logic          busy;
    logic          done;
    logic [CW-1:0] bits_left;
    logic [2:0]    state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shift_add_seq_ctrl #(
        .WIDTH(W),
        .CW   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .lsb       (lsb),
        .ld        (ld),
        .add       (add),
        .sh        (sh),
        .busy      (busy),
        .done      (done),
        .bits_left (bits_left),
        .state     (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One multiplication a*b. abort_at>0 cancels in that CHECK cycle; hold keeps
    // start asserted throughout. Entered and left at a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int abort_at, input bit hold);
        int ld_t = 0, n_ld = 0, done_t = 0, n_done = 0;
        int n_add = 0, n_sh = 0, n_chk = 0, abort_t = 0;
        int multi = 0, pair_bad = 0, bl_bad = 0, add_t = -10, bl_at_done = -1;
        int exp_done;
        logic [W:0]   hi = '0;
        logic [W-1:0] lo = '0;
        exp_done = 2 + 2 * W + $countones(b);
        start = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (abort_t != 0 && t == abort_t + 1) begin
                abort = 1'b0;
                chk("abort_state", 32'(state), 0);
                chk("abort_bits", 32'(bits_left), 0);
                chk("abort_busy", 32'(busy), 0);
            end
            if (int'(ld) + int'(add) + int'(sh) > 1) multi++;
            if (add_t == t - 1 && !sh) pair_bad++;
            if (ld) begin
                n_ld++;
                ld_t = t;
                hi = '0;
                lo = b;
            end
            if (add) begin
                n_add++;
                add_t = t;
                hi = {1'b0, hi[W-1:0]} + {1'b0, a};
            end
            if (sh) begin
                if (bits_left != CW'(W - n_sh)) bl_bad++;
                n_sh++;
                {hi, lo} = {hi, lo} >> 1;
            end
            if (done) begin
                n_done++;
                done_t = t;
                bl_at_done = int'(bits_left);
            end
            if (state == 3'b010) begin
                n_chk++;
                if (n_chk == abort_at) begin
                    abort = 1'b1;
                    abort_t = t;
                end
            end
            lsb = lo[0];
            if (done_t != 0 && t == done_t + 1) begin
                chk("busy_after_done", 32'(busy), 0);
                break;
            end
            if (abort_t != 0 && t == abort_t + 4) break;
        end
        chk("ld_once", n_ld, 1);
        chk("ld_time", ld_t, 1);
        chk("strobe_onehot", multi, 0);
        chk("add_then_sh", pair_bad, 0);
        if (abort_at == 0) begin
            chk("done_time", done_t, exp_done);
            chk("done_cnt", n_done, 1);
            chk("sh_cnt", n_sh, W);
            chk("add_cnt", n_add, $countones(b));
            chk("bits_seq", bl_bad, 0);
            chk("bits_at_done", bl_at_done, 0);
            chk("product", 32'({hi[W-1:0], lo}), 32'(a) * 32'(b));
        end else begin
            chk("abort_seen", abort_t != 0, 1);
            chk("abort_no_done", n_done, 0);
        end
    endtask

    task automatic reset_mid(input logic [2:0] target, input string tag);
        int seen = 0;
        int n_done = 0;
        start = 1'b1;
        lsb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 30 && seen == 0; t++) begin
            if (state == target) seen = 1;
            else @(negedge clk);
        end
        chk({tag, "_reached"}, seen, 1);
        rst = 1'b1;
        #1;
        chk({tag, "_outs"}, 32'({ld, add, sh, busy, done, bits_left, state}), 0);
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst = 1'b0;
        @(negedge clk);
        if (done) n_done++;
        chk({tag, "_no_done"}, n_done, 0);
        chk({tag, "_idle"}, 32'(state), 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        lsb = 1'b0;
        #1;
        chk("reset_outs", 32'({ld, add, sh, busy, done, bits_left, state}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 32'(state), 0);

        run_op(8'h37, 8'h00, 0, 1'b0);
        run_op(8'hC3, 8'hA5, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 0, 1'b0);
        run_op(8'h5A, 8'h6B, 5, 1'b0);
        @(negedge clk);
        run_op(8'h9D, 8'h01, 0, 1'b0);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_prio_state", 32'(state), 0);
        chk("abort_prio_busy", 32'(busy), 0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 0, 1'b1);
        end
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 0, 1'b0);
        end

        reset_mid(3'b001, "rst_load");
        reset_mid(3'b100, "rst_shift");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_add_seq_ctrl.md
# shift_add_seq_ctrl

Sequencing controller for the shift-and-add multiplier datapath. Accepts a start request, loads the operand registers, then steps through WIDTH multiplier bits, issuing an add strobe when the current multiplier LSB is 1 and a shift strobe every bit. An internal down-counter tracks the bits, so the datapath needs no zero-detect. It sits between the top-level handshake (start/done) and the datapath's load/add/shift/decrement enables.

## Interface
- WIDTH, 8, operand width in bits; number of shift iterations (≥2).
- CW, $clog2(WIDTH+1), bit-counter width (derived).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a multiplication; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- lsb  in  1  current multiplier LSB from the datapath.
- ld  out  1  load operands, clear accumulator (datapath enable).
- add  out  1  accumulate multiplicand into the product high half.
- sh  out  1  shift product/multiplier right by one.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: result valid.
- bits_left  out  CW  remaining iterations (debug/status).
- state  out  3  current state encoding (debug).

## Operation
- States: IDLE=000, LOAD=001, CHECK=010, ADD=011, SHIFT=100, DONE=101; 110/111 illegal and go to IDLE.
- IDLE: start=1 → LOAD; else stay. start is ignored in all other states.
- LOAD: ld=1, counter ← WIDTH; → CHECK.
- CHECK: no strobes; lsb=1 → ADD, lsb=0 → SHIFT.
- ADD: add=1; → SHIFT unconditionally.
- SHIFT: sh=1, counter ← counter−1; if counter==1 before decrement → DONE, else → CHECK.
- DONE: done=1; → IDLE. A start in DONE is ignored; it must be reasserted in IDLE.
- abort=1 in any state: next state IDLE and counter ← 0. No done pulse. abort has priority over every other transition, including start in IDLE.
- Moore outputs: ld, add, sh, busy, done and state are decoded from the state register only. No input affects outputs in the same cycle.
- At most one of ld/add/sh is high in any cycle.
- bits_left = counter register. It holds its value in IDLE/DONE and is 0 after reset or abort.

## Timing
- Reset (async assert): state=IDLE. ld=add=sh=busy=done=0, bits_left=0, state=000. Release is synchronous to clk with no extra delay states.
- Start accepted at edge k: LOAD occupies cycle k+1.
- Each bit takes 2 cycles (CHECK, SHIFT), or 3 cycles when lsb=1 (CHECK, ADD, SHIFT).
- done is high in cycle k + 2 + 2·WIDTH + ones(B), where ones(B) is the number of 1-bits in the multiplier. busy falls one cycle later.
- WIDTH=8 bounds: B=0x00 → done at k+18; B=0xFF → done at k+26.
- lsb is sampled only in CHECK. The datapath must present the post-shift LSB by the CHECK cycle following a SHIFT.
- Reset mid-operation: immediate return to reset values. No done pulse.

## Structure
- Package shift_add_pkg: state_t enum with the fixed encodings above, and the default WIDTH constant. It is shared with the datapath and its testbench.
- Sub-module bit_down_counter (parameter CW):
  - inputs: load, load_val, dec, clr
  - outputs: count, is_one
- The FSM is one always_ff for the state register plus one always_comb for next-state and output decode.

## Test plan
- Reset: assert rst mid-LOAD or mid-SHIFT → all outputs 0 and state=000 immediately (asynchronously), no done pulse.
- WIDTH=8, start with lsb held 0 (B=0x00) → ld at k+1, 8 sh pulses, 0 add pulses, done at k+18, busy low at k+19.
- B=0xA5 (lsb sequence 1,0,1,0,0,1,0,1) → 4 add pulses, each followed next cycle by sh; 8 sh pulses total; done at k+22.
- B=0xFF → 8 add and 8 sh pulses, done at k+26, bits_left counts 8→0.
- abort during the 5th CHECK → IDLE next cycle, bits_left=0, no done. A new start then runs a full 0x01 multiply with done at k+19.
- start held high continuously → new LOAD only after DONE→IDLE. start asserted while busy is ignored, giving exactly one done per IDLE acceptance.
